rr_mux_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 4x1 multiplexer datapath among four requesters.

---
 rtl/rr_mux_arbiter_pkg.sv | 15 +
 rtl/rr_mux_arbiter_if.sv | 13 +
 rtl/rr_mux_arbiter_dec2x4.sv | 8 +
 rtl/rr_mux_arbiter.sv | 57 +++++
 tb/tb_rr_mux_arbiter.sv | 126 ++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared constants, FSM encoding and round-robin search helper
package rr_mux_arbiter_pkg;
  localparam int NREQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  // Descending scan so the closest index after last wins
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] k;
    rr_pick = last;
    for (int i = NREQ; i >= 1; i--) begin
      k = last + SEL_W'(i);
      if (req[k]) rr_pick = k;
    end
  endfunction
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester/sink bundle between the arbiter and its environment
interface rr_mux_arbiter_if import rr_mux_arbiter_pkg::*; #(parameter int DW = 1);
  logic [NREQ-1:0] req;
  logic [NREQ*DW-1:0] data;
  logic out_ready;
  logic [NREQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic busy;
  modport master (output req, data, out_ready, input grant, sel, out_valid, out_data, busy);
  modport slave (input req, data, out_ready, output grant, sel, out_valid, out_data, busy);
endinterface

// File: rtl/rr_mux_arbiter_dec2x4.sv
// rr_mux_arbiter_dec2x4: enabled 2-to-4 one-hot decoder
module rr_mux_arbiter_dec2x4 import rr_mux_arbiter_pkg::*; (
  input logic [SEL_W-1:0] sel,
  input logic en,
  output logic [NREQ-1:0] onehot
);
  assign onehot = en ? NREQ'(1) << sel : '0;
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing a 4x1 mux with per-tenure beat limit
module rr_mux_arbiter import rr_mux_arbiter_pkg::*; #(
  parameter int DW = 1,
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic rst,
  rr_mux_arbiter_if.slave bus
);
  state_t state, nxt_state;
  logic [SEL_W-1:0] sel, nxt_sel, last_ptr, nxt_last;
  logic [3:0] beat_cnt, nxt_cnt;
  logic [NREQ-1:0] grant, nxt_grant;
  logic busy, beat, done;
  assign bus.out_valid = (state == ST_GRANT) && bus.req[sel];
  assign bus.out_data = (grant != '0) ? bus.data[sel*DW +: DW] : '0;
  assign beat = bus.out_valid && bus.out_ready;
  assign done = !bus.req[sel] || (beat && beat_cnt == 4'(MAX_HOLD - 1));
  assign bus.grant = grant;
  assign bus.sel = sel;
  assign bus.busy = busy;
  always_comb begin
    nxt_state = state;
    nxt_sel = sel;
    nxt_last = last_ptr;
    nxt_cnt = beat ? beat_cnt + 4'd1 : beat_cnt;
    if (state == ST_IDLE) begin
      if (|bus.req) begin
        nxt_state = ST_GRANT;
        nxt_sel = rr_pick(bus.req, last_ptr);
        nxt_cnt = '0;
      end
    end else if (done) begin
      nxt_state = ST_IDLE;
      nxt_last = sel;
      nxt_cnt = '0;
    end
  end
  rr_mux_arbiter_dec2x4 u_dec (.sel(nxt_sel), .en(nxt_state == ST_GRANT), .onehot(nxt_grant));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      sel <= '0;
      busy <= 1'b0;
      beat_cnt <= '0;
      last_ptr <= SEL_W'(NREQ - 1);
    end else begin
      state <= nxt_state;
      grant <= nxt_grant;
      sel <= nxt_sel;
      busy <= nxt_state == ST_GRANT;
      beat_cnt <= nxt_cnt;
      last_ptr <= nxt_last;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int failures = 0;
  rr_mux_arbiter_if #(.DW(1)) bus ();
  rr_mux_arbiter #(.DW(1), .MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic hold4(input string tag, input logic [3:0] g);
    for (int i = 0; i < 4; i++) begin
      chk(tag, bus.grant, g);
      tick();
    end
    chk({tag, "_gap"}, bus.grant, 4'b0000);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1;
    bus.req = 4'b1111;
    bus.data = 4'b0000;
    bus.out_ready = 0;
    tick();
    tick();
    chk("rst_grant", bus.grant, 4'b0000);
    chk("rst_sel", bus.sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    rst = 0;
    tick();
    chk("first_grant", bus.grant, 4'b0001);
    chk("first_busy", bus.busy, 1);
    chk("first_valid", bus.out_valid, 1);
    bus.req = 4'b0100;
    bus.data = 4'b0100;
    bus.out_ready = 1;
    tick();
    chk("drop0_gap", bus.grant, 4'b0000);
    chk("idle_data", bus.out_data, 0);
    chk("idle_busy", bus.busy, 0);
    tick();
    chk("g2_sel", bus.sel, 2);
    chk("g2_data", bus.out_data, 1);
    chk("g2_valid", bus.out_valid, 1);
    hold4("g2_a", 4'b0100);
    tick();
    chk("g2_regrant", bus.grant, 4'b0100);
    bus.req = 4'b1111;
    hold4("g2_b", 4'b0100);
    tick();
    hold4("rr3", 4'b1000);
    tick();
    hold4("rr0", 4'b0001);
    tick();
    hold4("rr1", 4'b0010);
    tick();
    hold4("rr2", 4'b0100);
    tick();
    hold4("rr3b", 4'b1000);
    tick();
    chk("rr0b", bus.grant, 4'b0001);
    bus.req = 4'b0010;
    bus.out_ready = 0;
    tick();
    chk("s4_gap", bus.grant, 4'b0000);
    tick();
    chk("s4_grant", bus.grant, 4'b0010);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_grant", bus.grant, 4'b0010);
      chk("stall_cnt", dut.beat_cnt, 0);
    end
    bus.out_ready = 1;
    hold4("s4_beats", 4'b0010);
    tick();
    chk("s5_grant", bus.grant, 4'b0010);
    bus.req = 4'b1011;
    tick();
    tick();
    chk("s5_hold", bus.grant, 4'b0010);
    bus.req = 4'b1001;
    tick();
    chk("s5_release", bus.grant, 4'b0000);
    tick();
    chk("s5_next3", bus.grant, 4'b1000);
    chk("s5_sel3", bus.sel, 3);
    hold4("s5_t3", 4'b1000);
    tick();
    chk("s5_next0", bus.grant, 4'b0001);
    bus.req = 4'b0100;
    tick();
    chk("s6_gap", bus.grant, 4'b0000);
    tick();
    chk("s6_grant", bus.grant, 4'b0100);
    tick();
    tick();
    chk("s6_cnt", dut.beat_cnt, 2);
    bus.req = 4'b1110;
    rst = 1;
    tick();
    chk("s6_rst_grant", bus.grant, 4'b0000);
    chk("s6_rst_busy", bus.busy, 0);
    chk("s6_rst_cnt", dut.beat_cnt, 0);
    rst = 0;
    tick();
    chk("s6_lowest", bus.grant, 4'b0010);
    chk("s6_sel", bus.sel, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
